ram_burst_arbiter: RTL and testbench
====================================

# ram_burst_arbiter

Arbitrates two burst requesters onto the single-port 256x16 operand RAM: requester 0 is the host loader, requester 1 is the field-arithmetic core. Each grant moves one field element, 1–15 sixteen-bit words (233-bit element = 15 words), at consecutive addresses. The block drives the RAM address, data and write-enable, and accounts for the RAM's 1-cycle registered read latency.

## Interface
- AW, 8, RAM address width
- DW, 16, RAM data width
- LW, 4, burst length width; length range 0..15 words
- clka  in  1  clock, shared with the RAM
- rsta  in  1  reset, synchronous, active-high
- req0 / req1  in  1  burst request; hold until the matching done pulse
- wr0 / wr1  in  1  burst direction, 1 = write to RAM; sampled at grant
- base0 / base1  in  AW  start address; sampled at grant
- len0 / len1  in  LW  word count; sampled at grant
- wdata0 / wdata1  in  DW  current write word
- gnt0 / gnt1  out  1  requester owns the RAM; one-hot or both 0
- take0 / take1  out  1  current wdata is written at this clock edge; requester advances to the next word
- rvalid0 / rvalid1  out  1  rdata holds a valid read word for this requester
- rdata  out  DW  read data, a direct wire from ram_dout
- done0 / done1  out  1  single-cycle burst-complete pulse
- ram_addr  out  AW  RAM address (registered)
- ram_din  out  DW  RAM write data, muxed from the granted wdata
- ram_we  out  1  RAM write enable
- ram_dout  in  DW  RAM registered output

## Operation
- FSM states: IDLE, WR, RD, DONE. Reset enters IDLE.
- **IDLE arbitration**
  - Only one req high: grant that requester.
  - Both req high: round-robin; the requester not served most recently wins. The pointer resets to favour requester 0.
  - At the grant edge: gnt_x←1; latch wr/base/len; ram_addr←base; cnt←0.
  - Next state: WR if wr=1, RD if wr=0, DONE if len=0.
- **WR**
  - ram_we=1, ram_din=wdata_x, take_x=1 every cycle.
  - At each edge: ram_addr←ram_addr+1, cnt←cnt+1.
  - After len words, go to DONE.
- **RD**
  - ram_we=0; ram_addr increments each cycle as in WR.
  - rvalid_x is registered: high in the cycle after each address cycle.
  - After len address cycles, go to DONE.
- **DONE** (one cycle)
  - done_x=1 and gnt_x remains 1.
  - For reads, rvalid_x=1 carries the last word.
  - Next state: IDLE; the round-robin pointer updates.
- Address arithmetic is modulo 2^AW: 255 wraps to 0 with no error.
- req is ignored outside IDLE. Dropping req mid-burst does not abort the burst.
- A req still high in the DONE cycle is re-granted in the following IDLE cycle. Requesters must deassert req in response to done.
- Outputs to a non-granted requester (take, rvalid, done) are always 0.

## Timing
- Reset values:
  - gnt, take, rvalid, done, ram_we: 0
  - ram_addr: 0
  - RR pointer: favour 0
  - rdata follows ram_dout and is not reset
- Write burst of L≥1 words: grant edge E0. Word k is written at edge E0+k+1, k=0..L-1. done appears in cycle L+1 after E0. Total occupancy is L+2 cycles, counting IDLE.
- Read burst of L≥1 words: addresses go out in cycles 1..L after E0. rvalid covers cycles 2..L+1. done coincides with the last rvalid.
- len=0: gnt for one cycle with done=1; no RAM access.
- Back-to-back grants: at least one IDLE cycle between bursts.
- rsta mid-burst: at the next edge all outputs return to reset values and the state goes to IDLE. No done is issued. A partially written element is left as-is.

## Configuration
- ARB_FIXED_PRIO_EN
  - Defined: requester 1 (core) always wins simultaneous requests; the RR pointer is removed.
  - Undefined: round-robin as specified.

## Test plan
- Reset, then req0 write with base=0x10, len=3, wdata 0xA1,0xA2,0xA3 → take0 high for 3 cycles; RAM[0x10..0x12]=A1,A2,A3; done0 in cycle 4.
- req1 read with base=0x10, len=3 → rvalid1 in cycles 2–4 with rdata A1,A2,A3; done1 together with the last rvalid.
- req0 and req1 asserted in the same cycle, twice in succession → grants go 0 then 1 (round-robin). With ARB_FIXED_PRIO_EN defined → 1 then 1.
- Write base=0xFE, len=4 → writes land at 0xFE, 0xFF, 0x00, 0x01.
- len=0 request → one cycle of gnt with done, ram_we never asserted.
- rsta asserted in cycle 2 of a 15-word write → all outputs 0 at the next edge; no done; a fresh req1 is granted afterwards with no stale state.

Source files
------------

// File: rtl/ram_burst_arbiter.sv
// Two-requester burst arbiter for the single-port 256x16 operand RAM.
// Define ARB_FIXED_PRIO_EN to make requester 1 always win simultaneous requests.
module ram_burst_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 4
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] base0,
  input  logic [AW-1:0] base1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          take0,
  output logic          take1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          done0,
  output logic          done1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  state_t        state;
  logic          owner;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt;
  logic          pick;
  logic          any;
  logic          sel_wr;
  logic [AW-1:0] sel_base;
  logic [LW-1:0] sel_len;
  logic          last;

`ifdef ARB_FIXED_PRIO_EN
  assign pick = req1;
`else
  // prefer names the requester not served most recently
  logic prefer;
  assign pick = (req0 && req1) ? prefer : req1;
`endif

  assign any      = req0 | req1;
  assign sel_wr   = pick ? wr1 : wr0;
  assign sel_base = pick ? base1 : base0;
  assign sel_len  = pick ? len1 : len0;
  assign last     = (cnt == len_q - LW'(1));

  assign take0   = ram_we & gnt0;
  assign take1   = ram_we & gnt1;
  assign ram_din = owner ? wdata1 : wdata0;
  assign rdata   = ram_dout;

  always_ff @(posedge clka) begin
    if (rsta) begin
      state    <= IDLE;
      owner    <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
`ifndef ARB_FIXED_PRIO_EN
      prefer   <= 1'b0;
`endif
    end else begin
      // read data returns one cycle after its address cycle
      rvalid0 <= (state == RD) && !owner;
      rvalid1 <= (state == RD) && owner;
      unique case (state)
        IDLE: begin
          if (any) begin
            owner    <= pick;
            gnt0     <= ~pick;
            gnt1     <= pick;
            ram_addr <= sel_base;
            len_q    <= sel_len;
            cnt      <= '0;
            if (sel_len == '0) begin
              state <= DONE;
              done0 <= ~pick;
              done1 <= pick;
            end else if (sel_wr) begin
              state  <= WR;
              ram_we <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        WR, RD: begin
          ram_addr <= ram_addr + AW'(1);
          cnt      <= cnt + LW'(1);
          if (last) begin
            state  <= DONE;
            ram_we <= 1'b0;
            done0  <= ~owner;
            done1  <= owner;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          prefer <= ~owner;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Randomized bench for ram_burst_arbiter with a behavioural RAM and a
// burst-level reference model predicting grants, strobes and read data.
module tb_ram_burst_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rsta;
  logic        req0, req1, wr0, wr1;
  logic [7:0]  base0, base1;
  logic [3:0]  len0, len1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, take0, take1;
  logic        rvalid0, rvalid1, done0, done1;
  logic [15:0] rdata, ram_din, ram_dout;
  logic [7:0]  ram_addr;
  logic        ram_we;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  bit          ref_val [256];
  logic [15:0] dat [2][16];
  int          n_chk = 0;
  int          n_err = 0;
  int          last_srv;
  logic [7:0]  last_wbase;

  ram_burst_arbiter dut (
    .clka(clk), .rsta(rsta),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .base0(base0), .base1(base1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .take0(take0), .take1(take1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .done0(done0), .done1(done1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // single-port RAM with registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {gnt0, gnt1, take0, take1, rvalid0, rvalid1, done0, done1, ram_we};
  endfunction

  task automatic drive(input int r, input bit q, input bit w,
                       input logic [7:0] b, input logic [3:0] l);
    if (r == 0) begin
      req0 = q; wr0 = w; base0 = b; len0 = l;
    end else begin
      req1 = q; wr1 = w; base1 = b; len1 = l;
    end
  endtask

  task automatic set_wd(input int r, input logic [15:0] v);
    if (r == 0) wdata0 = v;
    else wdata1 = v;
  endtask

  task automatic fill(input int r);
    for (int i = 0; i < 16; i++) dat[r][i] = 16'($urandom);
  endtask

  // Called in an IDLE cycle; grant is expected at the next edge.
  task automatic do_burst(input int r, input bit w, input logic [7:0] b,
                          input logic [3:0] l);
    int idx;
    int lst;
    int n;
    bit g, tk, rv, dn;
    logic [8:0] e;
    logic [7:0] a;
    n = int'(l);
    drive(r, 1'b1, w, b, l);
    set_wd(r, dat[r][0]);
    if (w) begin
      for (int i = 0; i < n; i++) begin
        a = b + 8'(i);
        ref_mem[a] = dat[r][i];
        ref_val[a] = 1'b1;
      end
      last_wbase = b;
    end
    idx = 0;
    lst = (n == 0) ? 1 : n + 1;
    for (int k = 0; k <= lst; k++) begin
      @(negedge clk);
      g  = k >= 1;
      tk = w && k >= 1 && k <= n;
      rv = !w && k >= 2 && k <= n + 1;
      dn = k == lst;
      e = {g && r == 0, g && r == 1, tk && r == 0, tk && r == 1,
           rv && r == 0, rv && r == 1, dn && r == 0, dn && r == 1, tk};
      check("ctl", 32'(ctl()), 32'(e));
      if (k >= 1 && k <= n) begin
        a = b + 8'(k - 1);
        check("addr", 32'(ram_addr), 32'(a));
      end
      if (tk) check("din", 32'(ram_din), 32'(dat[r][k-1]));
      if (rv) begin
        a = b + 8'(k - 2);
        if (ref_val[a]) check("rdata", 32'(rdata), 32'(ref_mem[a]));
      end
      @(posedge clk);
      #1;
      if (tk && idx < 15) idx++;
      set_wd(r, dat[r][idx]);
      if (k == lst) drive(r, 1'b0, w, b, l);
    end
    last_srv = r;
  endtask

  task automatic dual(input bit w0, input logic [7:0] b0, input logic [3:0] l0,
                      input bit w1, input logic [7:0] b1, input logic [3:0] l1);
    int win;
    fill(0);
    fill(1);
    drive(0, 1'b1, w0, b0, l0);
    drive(1, 1'b1, w1, b1, l1);
    set_wd(0, dat[0][0]);
    set_wd(1, dat[1][0]);
`ifdef ARB_FIXED_PRIO_EN
    win = 1;
`else
    win = (last_srv == 0) ? 1 : 0;
`endif
    if (win == 0) begin
      do_burst(0, w0, b0, l0);
      do_burst(1, w1, b1, l1);
    end else begin
      do_burst(1, w1, b1, l1);
      do_burst(0, w0, b0, l0);
    end
  endtask

  initial begin
    int r;
    bit w;
    logic [7:0] b;
    logic [3:0] l;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      ref_val[i] = 1'b0;
    end
    rsta = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0;
    wdata0 = '0; wdata1 = '0;
    last_srv = 1;
    last_wbase = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 32'(ctl()), 32'd0);
    check("reset_addr", 32'(ram_addr), 32'd0);
    @(posedge clk);
    #1;
    rsta = 1'b0;
    @(posedge clk);
    #1;

    dat[0][0] = 16'h00A1;
    dat[0][1] = 16'h00A2;
    dat[0][2] = 16'h00A3;
    do_burst(0, 1'b1, 8'h10, 4'd3);
    do_burst(1, 1'b0, 8'h10, 4'd3);
    dual(1'b1, 8'h20, 4'd2, 1'b0, 8'h10, 4'd3);
    dual(1'b0, 8'h20, 4'd2, 1'b1, 8'h30, 4'd5);
    fill(0);
    do_burst(0, 1'b1, 8'hFE, 4'd4);
    do_burst(1, 1'b0, 8'hFE, 4'd4);
    do_burst(1, 1'b1, 8'h50, 4'd0);

    // reset two cycles into a 15-word write
    fill(0);
    drive(0, 1'b1, 1'b1, 8'h40, 4'd15);
    set_wd(0, dat[0][0]);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_c1_gnt", 32'(gnt0), 32'd1);
    @(posedge clk);
    #1;
    set_wd(0, dat[0][1]);
    rsta = 1'b1;
    drive(0, 1'b0, 1'b1, 8'h40, 4'd15);
    @(negedge clk);
    check("rst_c2_take", 32'(take0), 32'd1);
    @(posedge clk);
    #1;
    rsta = 1'b0;
    @(negedge clk);
    check("rst_ctl", 32'(ctl()), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    ref_mem[8'h40] = dat[0][0];
    ref_mem[8'h41] = dat[0][1];
    ref_val[8'h40] = 1'b1;
    ref_val[8'h41] = 1'b1;
    last_srv = 1;
    @(posedge clk);
    #1;
    do_burst(1, 1'b0, 8'h40, 4'd3);

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      l = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 1) == 1) ? last_wbase : 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        dual(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)),
             w, b, l);
      end else begin
        fill(r);
        do_burst(r, w, b, l);
      end
    end

    for (int i = 0; i < 256; i++)
      if (ref_val[i]) check("mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
